// File: rtl/rca_pkg.sv
// Shared definitions for the chunked ripple-carry adder sequencer:
// controller states and default geometry (4 passes of 50 bits).
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_CHUNK_W    = 50;
    localparam int DEF_NUM_CHUNKS = 4;

endpackage

// File: rtl/ripple_carry_adder_50bit.sv
// One chunk of the adder datapath: WIDTH-bit add with carry in and carry out.
// The name reflects the default chunk width; WIDTH follows CHUNK_W.
module ripple_carry_adder_50bit #(
    parameter int WIDTH = 50
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle wide adder: one CHUNK_W adder reused over NUM_CHUNKS passes.
// Define RCA_SEQ_OVERFLOW_EN to add the signed-overflow output o_overflow.
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int CHUNK_W    = DEF_CHUNK_W,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
    localparam int OP_W      = CHUNK_W * NUM_CHUNKS
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [OP_W-1:0] i_add_term1,
    input  logic [OP_W-1:0] i_add_term2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [OP_W:0]   o_result,
    output logic            o_busy
`ifdef RCA_SEQ_OVERFLOW_EN
    ,
    output logic            o_overflow
`endif
);

    localparam int CNT_W = $clog2(NUM_CHUNKS);

    state_t             state;
    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CHUNK_W-1:0] chunk_sum;
    logic               chunk_cout;

    ripple_carry_adder_50bit #(
        .WIDTH(CHUNK_W)
    ) u_adder (
        .a    (a_q[CHUNK_W-1:0]),
        .b    (b_q[CHUNK_W-1:0]),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    assign o_busy = (state != IDLE);

`ifdef RCA_SEQ_OVERFLOW_EN
    // Carry into the top bit is recovered from the top bit's own sum and inputs.
    logic chunk_ovf;
    assign chunk_ovf = a_q[CHUNK_W-1] ^ b_q[CHUNK_W-1] ^ chunk_sum[CHUNK_W-1] ^ chunk_cout;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef RCA_SEQ_OVERFLOW_EN
            o_overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= 1'b1;
                    if (o_ready && i_valid) begin
                        a_q      <= i_add_term1;
                        b_q      <= i_add_term2;
                        carry_q  <= 1'b0;
                        cnt_q    <= '0;
                        o_result <= '0;
                        o_ready  <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK_W;
                    b_q     <= b_q >> CHUNK_W;
                    carry_q <= chunk_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Chunk sums enter from the top so chunk 0 ends at the bottom.
                    if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
                        o_result <= {chunk_cout, chunk_sum, o_result[OP_W-1:CHUNK_W]};
                        o_valid  <= 1'b1;
                        state    <= DONE;
`ifdef RCA_SEQ_OVERFLOW_EN
                        o_overflow <= chunk_ovf;
`endif
                    end else begin
                        o_result[OP_W-1:0] <= {chunk_sum, o_result[OP_W-1:CHUNK_W]};
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
`ifdef RCA_SEQ_OVERFLOW_EN
                        o_overflow <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed vector table, hold/abort
// sequences and random operands against a plain-arithmetic reference.
module tb_rca_seq_ctrl;

    localparam int CW   = 50;
    localparam int NC   = 4;
    localparam int OP_W = CW * NC;

    logic            i_clk;
    logic            i_rst;
    logic            i_valid;
    logic            o_ready;
    logic [OP_W-1:0] i_add_term1;
    logic [OP_W-1:0] i_add_term2;
    logic            o_valid;
    logic            i_ready;
    logic [OP_W:0]   o_result;
    logic            o_busy;
`ifdef RCA_SEQ_OVERFLOW_EN
    logic            o_overflow;
`endif

    int checks = 0;
    int errors = 0;

    rca_seq_ctrl #(
        .CHUNK_W   (CW),
        .NUM_CHUNKS(NC)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_add_term1(i_add_term1),
        .i_add_term2(i_add_term2),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_busy     (o_busy)
`ifdef RCA_SEQ_OVERFLOW_EN
        ,
        .o_overflow (o_overflow)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic [OP_W:0]   res;
        logic            ovf;
    } vec_t;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [OP_W:0] act, input logic [OP_W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [OP_W:0] pow2(input int n);
        return (OP_W+1)'(1) << n;
    endfunction

    function automatic logic [OP_W-1:0] low_ones(input int n);
        logic [OP_W:0] t;
        t = pow2(n) - (OP_W+1)'(1);
        return t[OP_W-1:0];
    endfunction

    function automatic logic [OP_W-1:0] rnd_op();
        logic [OP_W-1:0] v;
        v = '0;
        for (int i = 0; i < (OP_W + 31) / 32; i++) v = {v[OP_W-33:0], 32'($urandom)};
        return v;
    endfunction

    // Reference: full-width unsigned sum and two's-complement overflow rule.
    function automatic logic [OP_W:0] model_sum(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic model_ovf(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        logic [OP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (a[OP_W-1] == b[OP_W-1]) && (s[OP_W-1] != a[OP_W-1]);
    endfunction

    function automatic logic cur_ovf();
`ifdef RCA_SEQ_OVERFLOW_EN
        return o_overflow;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input bit noisy,
                          output logic [OP_W:0] res, output logic ovf, output int lat);
        int w;
        w = 0;
        while (!o_ready && w < 20) begin
            step();
            w++;
        end
        check1("ready_before_accept", o_ready, 1'b1);
        i_add_term1 = a;
        i_add_term2 = b;
        i_valid     = 1'b1;
        step();
        check1("busy_after_accept", o_busy, 1'b1);
        check1("ready_low_in_run", o_ready, 1'b0);
        if (noisy) begin
            i_add_term1 = rnd_op();
            i_add_term2 = rnd_op();
        end else begin
            i_valid = 1'b0;
        end
        lat = 0;
        while (!o_valid && lat < 50) begin
            step();
            lat++;
        end
        i_valid = 1'b0;
        res     = o_result;
        ovf     = cur_ovf();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check1("ready_after_release", o_ready, 1'b1);
        check1("valid_after_release", o_valid, 1'b0);
    endtask

    initial begin
        vec_t            vecs[7];
        logic [OP_W:0]   res;
        logic [OP_W:0]   held;
        logic            ovf;
        int              lat;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        bit              saw;

        vecs[0] = '{a: '0, b: '0, res: '0, ovf: 1'b0};
        vecs[1] = '{a: low_ones(50), b: OP_W'(1), res: pow2(50), ovf: 1'b0};
        vecs[2] = '{a: {OP_W{1'b1}}, b: OP_W'(1), res: pow2(200), ovf: 1'b0};
        vecs[3] = '{a: low_ones(199), b: OP_W'(1), res: pow2(199), ovf: 1'b1};
        vecs[4] = '{a: low_ones(100), b: low_ones(100), res: pow2(101) - (OP_W+1)'(2), ovf: 1'b0};
        vecs[5] = '{a: {OP_W{1'b1}}, b: {OP_W{1'b1}}, res: {1'b1, {(OP_W-1){1'b1}}, 1'b0}, ovf: 1'b0};
        vecs[6] = '{a: {1'b1, {(OP_W-1){1'b0}}}, b: {1'b1, {(OP_W-1){1'b0}}}, res: pow2(200), ovf: 1'b1};

        i_rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_add_term1 = '0;
        i_add_term2 = '0;
        step();
        step();
        check1("rst_ready", o_ready, 1'b0);
        check1("rst_valid", o_valid, 1'b0);
        check1("rst_busy", o_busy, 1'b0);
        check("rst_result", o_result, '0);
        i_rst = 1'b0;
        step();
        check1("ready_after_rst", o_ready, 1'b1);
        check1("busy_after_rst", o_busy, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, res, ovf, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), (OP_W+1)'(lat), (OP_W+1)'(NC));
`ifdef RCA_SEQ_OVERFLOW_EN
            check1($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
        end

        // Result held while the consumer stalls; new requests ignored.
        a = rnd_op();
        b = rnd_op();
        i_add_term1 = a;
        i_add_term2 = b;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 50) begin
            step();
            lat++;
        end
        check1("hold_valid_seen", o_valid, 1'b1);
        held = o_result;
        check("hold_result", held, model_sum(a, b));
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_add_term1 = rnd_op();
            i_add_term2 = rnd_op();
            step();
            check1("hold_valid_stable", o_valid, 1'b1);
            check("hold_result_stable", o_result, held);
            check1("hold_ready_low", o_ready, 1'b0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check1("hold_ready_after_release", o_ready, 1'b1);
        check1("hold_valid_after_release", o_valid, 1'b0);

        // Abort in the middle of RUN.
        i_add_term1 = rnd_op();
        i_add_term2 = rnd_op();
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        i_rst = 1'b1;
        step();
        check1("abort_valid", o_valid, 1'b0);
        check1("abort_busy", o_busy, 1'b0);
        check1("abort_ready", o_ready, 1'b0);
        check("abort_result", o_result, '0);
`ifdef RCA_SEQ_OVERFLOW_EN
        check1("abort_ovf", o_overflow, 1'b0);
`endif
        step();
        i_rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < NC + 2; k++) begin
            step();
            if (o_valid) saw = 1'b1;
        end
        check1("abort_no_valid", saw, 1'b0);
        a = rnd_op();
        b = rnd_op();
        run_op(a, b, 1'b0, res, ovf, lat);
        check("abort_fresh_result", res, model_sum(a, b));

        // Random operands, some with carry-heavy relations and noisy i_valid.
        for (int n = 0; n < 24; n++) begin
            a = rnd_op();
            case ($urandom_range(0, 3))
                0: b = ~a;
                1: b = ~a + OP_W'(1);
                2: b = {OP_W{1'b1}};
                default: b = rnd_op();
            endcase
            run_op(a, b, bit'($urandom_range(0, 1)), res, ovf, lat);
            check($sformatf("rand%0d_result", n), res, model_sum(a, b));
            check($sformatf("rand%0d_latency", n), (OP_W+1)'(lat), (OP_W+1)'(NC));
`ifdef RCA_SEQ_OVERFLOW_EN
            check1($sformatf("rand%0d_ovf", n), ovf, model_ovf(a, b));
`else
            if (ovf !== 1'b0 && model_ovf(a, b) === 1'bx) $display("unexpected overflow state");
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 SHALL have parameter CHUNK_W, default 50, meaning the width of one adder pass in bits.
REQ-002 SHALL have parameter NUM_CHUNKS, default 4, meaning the number of passes per operation (range 2..16); OP_W = CHUNK_W*NUM_CHUNKS.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports i_valid (input, 1 bit) and o_ready (output, 1 bit): the operand handshake.
REQ-006 SHALL have ports i_add_term1 and i_add_term2, input, OP_W bits each: the unsigned operands.
REQ-007 SHALL have ports o_valid (output, 1 bit) and i_ready (input, 1 bit): the result handshake.
REQ-008 SHALL have port o_result, output, OP_W+1 bits: the sum, with the MSB as the final carry.
REQ-009 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 SHALL implement the states IDLE, RUN and DONE, encoded as a 2-bit state register.
REQ-011 SHALL drive o_ready=1 only in IDLE, from registered state with no combinational path from i_valid.
REQ-012 SHALL, in IDLE with i_valid=1, capture both operands into shift registers, clear the carry register and the chunk counter, and go to RUN.
REQ-013 SHALL, in RUN, add each cycle the low CHUNK_W bits of both operand registers plus the carry register, and shift the chunk sum into o_result from the top.
REQ-014 SHALL, in RUN, each cycle shift the operand registers right by CHUNK_W, register the chunk carry-out and increment the counter.
REQ-015 SHALL, when the counter reaches NUM_CHUNKS-1, write the final carry to o_result[OP_W] and go to DONE.
REQ-016 SHALL assert o_valid in DONE only, exactly NUM_CHUNKS cycles after the accepting edge.
REQ-017 SHALL hold o_result and o_valid stable in DONE until i_ready=1, then return to IDLE.
REQ-018 SHALL give o_ready=1 on the cycle after result release, for a throughput of 1 operation per NUM_CHUNKS+2 cycles.
REQ-019 SHALL ignore i_valid outside IDLE, with the operand registers unaffected.
REQ-020 SHALL make the carry chain across chunks exact: o_result equals i_add_term1+i_add_term2 modulo 2^(OP_W+1), with no truncation.

Reset
REQ-021 SHALL, while i_rst=1, set state=IDLE, o_valid=0, o_busy=0, o_result=0, the carry register, counter and operand registers to 0, and o_ready=0.
REQ-022 SHALL drive o_ready=1 from the first cycle after i_rst deasserts.
REQ-023 SHALL, on reset asserted in RUN or DONE, abort the operation, discard the partial result and produce no o_valid pulse.

Configuration
REQ-024 SHALL, with macro RCA_SEQ_OVERFLOW_EN defined, add output o_overflow (1 bit), registered and qualified by o_valid.
REQ-025 SHALL compute o_overflow as signed two's-complement overflow (carry into bit OP_W-1 XOR carry out of bit OP_W-1), reset value 0.
REQ-026 SHALL, without RCA_SEQ_OVERFLOW_EN, have no o_overflow port and no related logic.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/DONE) and the default CHUNK_W and NUM_CHUNKS constants in shared package rca_pkg.
REQ-028 SHALL use exactly one chunk datapath, a single instance of ripple_carry_adder_50bit (CHUNK_W wide), with its carry input fed from the carry register.

Verification
REQ-029 SHALL cover 0+0: o_result=0, o_valid 4 cycles after accept, and o_overflow=0.
REQ-030 SHALL cover a=2^50-1, b=1: o_result=2^50, proving carry propagation across the chunk 0/1 boundary.
REQ-031 SHALL cover a=2^200-1, b=1: o_result=2^200 (MSB=1, rest 0), and o_overflow=0.
REQ-032 SHALL cover a=2^199-1, b=1 with the macro defined: o_result=2^199 and o_overflow=1.
REQ-033 SHALL cover i_ready held low 5 cycles in DONE: o_result and o_valid stable, a new i_valid ignored, and o_ready=1 one cycle after release.
REQ-034 SHALL cover i_rst pulsed during RUN cycle 2: no o_valid, all outputs 0, then a fresh operation returning the correct sum.
